updown_cnt_sched: RTL



---
 rtl/updown_cnt_sched.sv | 174 +++++++++++++++++
 1 files changed

// File: rtl/updown_cnt_sched.sv
// Round-robin scheduler that walks one shared wrap-around up/down counter to per-requester targets.
// Optional step-budget timeout is enabled with `define UPDOWN_CNT_SCHED_TIMEOUT_EN.
module updown_cnt_sched #(
  parameter int unsigned NREQ  = 4,
  parameter int unsigned WIDTH = 4
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic [NREQ-1:0]         req_i,
  input  logic [NREQ*WIDTH-1:0]   tgt_i,
  input  logic [WIDTH-1:0]        cnt_i,
  output logic                    ce_o,
  output logic                    ctr_o,
  output logic [NREQ-1:0]         gnt_o,
  output logic [NREQ-1:0]         done_o,
  output logic                    busy_o,
  output logic                    err_o
);

  localparam int unsigned IdxW = (NREQ > 1) ? $clog2(NREQ) : 1;

  typedef enum logic [1:0] {
    StIdle,
    StCmp,
    StStep,
    StDone
  } state_e;

  state_e            r_state, w_state_nxt;
  logic [IdxW-1:0]   r_ptr, w_ptr_nxt;
  logic [IdxW-1:0]   r_idx, w_idx_nxt;
  logic [WIDTH-1:0]  r_tgt, w_tgt_nxt;
  logic              r_dir, w_dir_nxt;

  logic [IdxW-1:0]   w_sel;
  logic              w_any;
  logic [IdxW-1:0]   w_idx_inc;
  logic [WIDTH-1:0]  w_up;
  logic [WIDTH-1:0]  w_dn;
  logic [NREQ-1:0]   w_onehot;

`ifdef UPDOWN_CNT_SCHED_TIMEOUT_EN
  // A well-behaved counter never needs more than half the modulus in steps.
  localparam logic [WIDTH-1:0] StepMax = WIDTH'(1 << (WIDTH - 1));

  logic [WIDTH-1:0]  r_steps, w_steps_nxt;
  logic              r_err, w_err_nxt;
`endif

  function automatic logic [IdxW-1:0] wrap_idx(input int unsigned base, input int unsigned off);
    return IdxW'((base + off) % NREQ);
  endfunction

  // First requesting index at or after the pointer, scanning upward with wrap.
  always_comb begin
    w_sel = '0;
    w_any = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      if (!w_any && req_i[wrap_idx(32'(r_ptr), unsigned'(i))]) begin
        w_sel = wrap_idx(32'(r_ptr), unsigned'(i));
        w_any = 1'b1;
      end
    end
  end

  assign w_idx_inc = (r_idx == IdxW'(NREQ - 1)) ? '0 : r_idx + 1'b1;
  assign w_up      = r_tgt - cnt_i;
  assign w_dn      = cnt_i - r_tgt;
  assign w_onehot  = NREQ'(1) << r_idx;

  always_comb begin
    w_state_nxt = r_state;
    w_ptr_nxt   = r_ptr;
    w_idx_nxt   = r_idx;
    w_tgt_nxt   = r_tgt;
    w_dir_nxt   = r_dir;
`ifdef UPDOWN_CNT_SCHED_TIMEOUT_EN
    w_steps_nxt = r_steps;
    w_err_nxt   = r_err;
`endif
    case (r_state)
      StIdle: begin
        if (w_any) begin
          w_idx_nxt   = w_sel;
          w_tgt_nxt   = tgt_i[w_sel*WIDTH +: WIDTH];
          w_state_nxt = StCmp;
`ifdef UPDOWN_CNT_SCHED_TIMEOUT_EN
          w_steps_nxt = '0;
          w_err_nxt   = 1'b0;
`endif
        end
      end
      StCmp: begin
        if (!req_i[r_idx]) begin
          w_ptr_nxt   = w_idx_inc;
          w_state_nxt = StIdle;
        end else if (cnt_i == r_tgt) begin
          w_state_nxt = StDone;
`ifdef UPDOWN_CNT_SCHED_TIMEOUT_EN
        end else if (r_steps == StepMax) begin
          w_err_nxt   = 1'b1;
          w_state_nxt = StDone;
`endif
        end else begin
          // Ties take the upward path.
          w_dir_nxt   = (w_up <= w_dn);
          w_state_nxt = StStep;
        end
      end
      StStep: begin
        w_state_nxt = StCmp;
`ifdef UPDOWN_CNT_SCHED_TIMEOUT_EN
        w_steps_nxt = r_steps + 1'b1;
`endif
      end
      StDone: begin
        w_ptr_nxt   = w_idx_inc;
        w_state_nxt = StIdle;
      end
      default: w_state_nxt = StIdle;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state <= StIdle;
      r_ptr   <= '0;
      r_idx   <= '0;
      r_tgt   <= '0;
      r_dir   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_ptr   <= w_ptr_nxt;
      r_idx   <= w_idx_nxt;
      r_tgt   <= w_tgt_nxt;
      r_dir   <= w_dir_nxt;
    end
  end

`ifdef UPDOWN_CNT_SCHED_TIMEOUT_EN
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_steps <= '0;
      r_err   <= 1'b0;
    end else begin
      r_steps <= w_steps_nxt;
      r_err   <= w_err_nxt;
    end
  end

  assign err_o = r_err && (r_state == StDone);
`else
  assign err_o = 1'b0;
`endif

  always_comb begin
    gnt_o  = '0;
    done_o = '0;
    ce_o   = 1'b0;
    case (r_state)
      StCmp:  gnt_o = w_onehot;
      StStep: begin
        gnt_o = w_onehot;
        ce_o  = 1'b1;
      end
      StDone: done_o = w_onehot;
      default: ;
    endcase
  end

  assign ctr_o  = r_dir;
  assign busy_o = (r_state != StIdle);

endmodule
